// File: rtl/ahb3lite_irq_ctrl.sv
// AHB3-Lite interrupt aggregator: synchronises peripheral interrupt lines, latches
// them as edge or level sources, masks them and drives a single registered irq.
module ahb3lite_irq_ctrl #(
  parameter int SOURCES    = 8,
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [SOURCES-1:0]    src,
  output logic                  irq
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_TYPE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  logic                  ap_valid;
  logic [3:0]            ap_lanes;
  logic                  dp_valid;
  logic                  dp_write;
  logic                  dp_hit;
  logic [1:0]            dp_reg;
  logic [3:0]            dp_lanes;
  logic [HDATA_SIZE-1:0] lane_bits;
  logic [HDATA_SIZE-1:0] wr_full;
  logic [SOURCES-1:0]    wr_data;
  logic                  we;
  logic                  re;
  logic [SOURCES-1:0]    s1, s2, s3;
  logic [SOURCES-1:0]    rise;
  logic [SOURCES-1:0]    w1c;
  logic [SOURCES-1:0]    pending;
  logic [SOURCES-1:0]    ienable;
  logic [SOURCES-1:0]    itype;
  logic [HDATA_SIZE-1:0] claim;
  logic                  unused;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign ap_valid = HSEL & HREADY & HTRANS[1];

  always_comb begin
    ap_lanes = 4'b1111;
    case (HSIZE)
      3'b000:  ap_lanes = 4'b0001 << HADDR[1:0];
      3'b001:  ap_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_hit   <= 1'b0;
      dp_reg   <= 2'd0;
      dp_lanes <= 4'd0;
    end else begin
      dp_valid <= ap_valid;
      if (ap_valid) begin
        dp_write <= HWRITE;
        dp_reg   <= HADDR[3:2];
        dp_lanes <= ap_lanes;
        dp_hit   <= (HADDR[HADDR_SIZE-1:4] == '0);
      end
    end
  end

  always_comb begin
    lane_bits = '0;
    for (int b = 0; b < HDATA_SIZE / 8; b++) begin
      lane_bits[b*8 +: 8] = {8{dp_lanes[b]}};
    end
  end

  assign wr_full = HWDATA & lane_bits;
  assign wr_data = wr_full[SOURCES-1:0];
  assign we      = dp_valid & dp_write & dp_hit;
  assign re      = dp_valid & ~dp_write & dp_hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  // W1C only reaches edge sources; a simultaneous new edge still wins over it.
  assign w1c  = (we && dp_reg == REG_PENDING) ? (wr_data & itype) : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending <= '0;
      ienable <= '0;
      itype   <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= (itype & ((pending & ~w1c) | rise)) | (~itype & s2);
      if (we && dp_reg == REG_ENABLE) ienable <= (ienable & ~lane_bits[SOURCES-1:0]) | wr_data;
      if (we && dp_reg == REG_TYPE)   itype   <= (itype & ~lane_bits[SOURCES-1:0]) | wr_data;
      irq <= |(pending & ienable);
    end
  end

  always_comb begin
    claim = '0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (pending[i] && ienable[i]) claim = HDATA_SIZE'(i + 1);
    end
  end

  // Read data is combinational in the data phase, so a same-cycle write is not yet visible.
  always_comb begin
    HRDATA = '0;
    if (re) begin
      case (dp_reg)
        REG_PENDING: HRDATA[SOURCES-1:0] = pending;
        REG_ENABLE:  HRDATA[SOURCES-1:0] = ienable;
        REG_TYPE:    HRDATA[SOURCES-1:0] = itype;
        REG_CLAIM:   HRDATA = claim;
        default:     HRDATA = '0;
      endcase
    end
  end

  assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], wr_full, lane_bits};

endmodule

// File: tb/tb_ahb3lite_irq_ctrl.sv
// Directed bench for ahb3lite_irq_ctrl: bus access, edge/level latching,
// W1C races, enable masking, claim priority and asynchronous reset.
module tb_ahb3lite_irq_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [7:0]  src;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  ahb3lite_irq_ctrl #(.SOURCES(8), .HADDR_SIZE(16), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .src(src), .irq(irq)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic write, input logic [2:0] size);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = write;
    HSIZE  = size;
  endtask

  task automatic busIdle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [31:0] data, input logic [2:0] size);
    applyStimulus(addr, 1'b1, size);
    tick(1);
    busIdle();
    HWDATA = data;
    tick(1);
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [31:0] data);
    applyStimulus(addr, 1'b0, 3'b010);
    tick(1);
    busIdle();
    data = HRDATA;
    checkOutput("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("hresp", {31'd0, HRESP}, 32'd0);
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
    HSIZE = 3'b010; HBURST = '0; HPROT = '0; HTRANS = '0; HMASTLOCK = 1'b0;
    HREADY = 1'b1; src = '0;

    // Reset state
    #1;
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    checkOutput("rst_hresp", {31'd0, HRESP}, 32'd0);
    checkOutput("rst_hrdata", HRDATA, 32'd0);
    tick(3);
    HRESETn = 1'b1;
    busRead(16'h0, rd); checkOutput("rst_pending", rd, 32'd0);
    busRead(16'h4, rd); checkOutput("rst_enable", rd, 32'd0);
    busRead(16'h8, rd); checkOutput("rst_type", rd, 32'd0);
    busRead(16'hC, rd); checkOutput("rst_claim", rd, 32'd0);

    // Byte lanes and out-of-range offsets
    busWrite(16'h4, 32'hFFFF_FFFF, 3'b010);
    busRead(16'h4, rd); checkOutput("en_word", rd, 32'h0000_00FF);
    busWrite(16'h5, 32'h0000_5A00, 3'b000);
    busRead(16'h4, rd); checkOutput("en_byte_lane1", rd, 32'h0000_00FF);
    busWrite(16'h6, 32'h0000_0000, 3'b001);
    busRead(16'h4, rd); checkOutput("en_half_upper", rd, 32'h0000_00FF);
    busWrite(16'h4, 32'h0000_0003, 3'b001);
    busRead(16'h4, rd); checkOutput("en_half_lower", rd, 32'h0000_0003);
    busWrite(16'h14, 32'h0000_00FF, 3'b010);
    busRead(16'h4, rd); checkOutput("oor_write", rd, 32'h0000_0003);
    busRead(16'h14, rd); checkOutput("oor_read", rd, 32'd0);

    // Edge source latency
    busWrite(16'h8, 32'h1, 3'b010);
    busWrite(16'h4, 32'h1, 3'b010);
    src = 8'h01;
    tick(1);
    src = 8'h00;
    busRead(16'h0, rd); checkOutput("edge_pend_n1", rd, 32'd0);
    busRead(16'h0, rd); checkOutput("edge_pend_n2", rd, 32'd1);
    checkOutput("edge_irq_n2", {31'd0, irq}, 32'd0);
    tick(1);
    checkOutput("edge_irq_n3", {31'd0, irq}, 32'd1);
    busRead(16'hC, rd); checkOutput("edge_claim", rd, 32'd1);

    // W1C clear latency, then W1C racing a new edge
    busWrite(16'h0, 32'h1, 3'b010);
    checkOutput("w1c_irq_same", {31'd0, irq}, 32'd1);
    tick(1);
    checkOutput("w1c_irq_next", {31'd0, irq}, 32'd0);
    busRead(16'h0, rd); checkOutput("w1c_pending", rd, 32'd0);
    src = 8'h01;
    tick(1);
    src = 8'h00;
    busWrite(16'h0, 32'h1, 3'b010);
    busRead(16'h0, rd); checkOutput("race_pending", rd, 32'd1);
    checkOutput("race_irq", {31'd0, irq}, 32'd1);
    busWrite(16'h0, 32'h1, 3'b010);
    tick(1);
    checkOutput("race_cleared_irq", {31'd0, irq}, 32'd0);

    // Level source, ignored W1C, enable masking
    busWrite(16'h4, 32'h09, 3'b010);
    src = 8'h08;
    tick(4);
    checkOutput("lvl_irq", {31'd0, irq}, 32'd1);
    busRead(16'hC, rd); checkOutput("lvl_claim", rd, 32'd4);
    busWrite(16'h0, 32'h08, 3'b010);
    busRead(16'h0, rd); checkOutput("lvl_w1c_ignored", rd, 32'h08);
    busWrite(16'h4, 32'h01, 3'b010);
    checkOutput("dis_irq_same", {31'd0, irq}, 32'd1);
    tick(1);
    checkOutput("dis_irq_next", {31'd0, irq}, 32'd0);
    busWrite(16'h4, 32'h09, 3'b010);
    tick(1);
    checkOutput("reen_irq", {31'd0, irq}, 32'd1);
    src = 8'h00;
    tick(3);
    checkOutput("lvl_drop_n2", {31'd0, irq}, 32'd1);
    tick(1);
    checkOutput("lvl_drop_n3", {31'd0, irq}, 32'd0);

    // Claim priority, then reset in the middle of a burst
    busWrite(16'h4, 32'h24, 3'b010);
    src = 8'h24;
    tick(4);
    busRead(16'hC, rd); checkOutput("prio_claim", rd, 32'd3);
    busRead(16'h0, rd); checkOutput("prio_pending", rd, 32'h24);
    checkOutput("prio_irq", {31'd0, irq}, 32'd1);
    applyStimulus(16'h4, 1'b1, 3'b010);
    tick(1);
    HTRANS = 2'b11;
    HADDR  = 16'h8;
    HWDATA = 32'hFF;
    src    = 8'h00;
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
    checkOutput("midrst_hrdata", HRDATA, 32'd0);
    busIdle();
    tick(2);
    HRESETn = 1'b1;
    tick(2);
    busRead(16'h0, rd); checkOutput("post_pending", rd, 32'd0);
    busRead(16'h4, rd); checkOutput("post_enable", rd, 32'd0);
    busRead(16'h8, rd); checkOutput("post_type", rd, 32'd0);
    busRead(16'hC, rd); checkOutput("post_claim", rd, 32'd0);
    checkOutput("post_irq", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
